// File: rtl/keypad_pkg.sv
// Shared constants and event record for the 5x4 keypad scanner and its event FIFO.
package keypad_pkg;
  localparam int KP_ROWS       = 5;
  localparam int KP_COLS       = 4;
  localparam int KP_CODE_W     = 5;
  localparam int KP_FIFO_DEPTH = 4;
  localparam int KP_KEYS       = KP_ROWS * KP_COLS;

  typedef struct packed {
    logic                 press;
    logic [KP_CODE_W-1:0] code;
  } kp_evt_t;

  // Key code = row*4 + col.
  function automatic logic [KP_CODE_W-1:0] kp_code(input logic [2:0] row, input logic [1:0] col);
    return {row, 2'b00} + {3'b000, col};
  endfunction
endpackage

// File: rtl/keypad_evt_fifo.sv
// Small event FIFO: simultaneous push and pop on a full FIFO both succeed; a push
// into a full FIFO without a pop is dropped and flagged on drop_o.
module keypad_evt_fifo
  import keypad_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  kp_evt_t push_data_i,
  input  logic    pop_i,
  output kp_evt_t head_o,
  output logic    full_o,
  output logic    empty_o,
  output logic    drop_o
);
  localparam int PW = $clog2(KP_FIFO_DEPTH);

  kp_evt_t       mem_q [KP_FIFO_DEPTH];
  kp_evt_t       mem_d [KP_FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    full_o  = (cnt_q == (PW+1)'(KP_FIFO_DEPTH));
    empty_o = (cnt_q == '0);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    drop_o  = push_i && full_o && !do_pop;
    head_o  = empty_o ? '0 : mem_q[rd_q];

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data_i;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) rd_d = rd_q + PW'(1);
    if (do_push && !do_pop) cnt_d = cnt_q + (PW+1)'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KP_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 5x4 keypad scanner: one-cold row drive, per-key debounce, press/release events.
// Release events are generated only when KEYPAD_RELEASE_EVT_EN is defined.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [KP_ROWS-1:0]   btn_x,
  input  logic [KP_COLS-1:0]   btn_y,
  output logic [KP_KEYS-1:0]   key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KP_CODE_W-1:0] evt_code,
  output logic                 evt_press,
  output logic                 overflow
);
  localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_MAX     = 4'(DEBOUNCE_SCANS);
  localparam logic [3:0]  DB_SAT     = 4'(DEBOUNCE_SCANS - 1);

  logic [KP_COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [15:0]          dwell_q, dwell_d;
  logic [2:0]           row_q, row_d;
  logic [3:0]           cnt_q [KP_KEYS];
  logic [3:0]           cnt_d [KP_KEYS];
  logic [KP_KEYS-1:0]   key_state_q, key_state_d;
  logic                 push_q, push_d;
  kp_evt_t              push_evt_q, push_evt_d;
  logic                 overflow_q, overflow_d;

  logic                 sample;
  logic                 committed;
  logic                 level;
  logic [KP_CODE_W-1:0] key;
  kp_evt_t              evt_head;
  logic                 fifo_empty, fifo_drop, fifo_full_unused;

  always_comb begin
    sync1_d     = btn_y;
    sync2_d     = sync1_q;
    sample      = (dwell_q == DWELL_LAST);
    dwell_d     = sample ? '0 : dwell_q + 16'd1;
    row_d       = row_q;
    if (sample) row_d = (row_q == 3'(KP_ROWS - 1)) ? '0 : row_q + 3'd1;

    cnt_d       = cnt_q;
    key_state_d = key_state_q;
    push_d      = 1'b0;
    push_evt_d  = push_evt_q;
    committed   = 1'b0;
    level       = 1'b0;
    key         = '0;
    if (sample) begin
      // Lowest column commits first; later eligible keys wait one count short.
      for (int c = 0; c < KP_COLS; c++) begin
        key   = kp_code(row_q, 2'(c));
        level = ~sync2_q[c];
        if (level == key_state_q[key]) begin
          cnt_d[key] = '0;
        end else if (cnt_q[key] + 4'd1 >= DB_MAX) begin
          if (!committed) begin
            committed        = 1'b1;
            key_state_d[key] = level;
            cnt_d[key]       = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
            push_d           = 1'b1;
`else
            push_d           = level;
`endif
            push_evt_d       = '{press: level, code: key};
          end else begin
            cnt_d[key] = DB_SAT;
          end
        end else begin
          cnt_d[key] = cnt_q[key] + 4'd1;
        end
      end
    end
    overflow_d = overflow_q | fifo_drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      dwell_q     <= '0;
      row_q       <= '0;
      for (int i = 0; i < KP_KEYS; i++) cnt_q[i] <= '0;
      key_state_q <= '0;
      push_q      <= 1'b0;
      push_evt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_state_q <= key_state_d;
      push_q      <= push_d;
      push_evt_q  <= push_evt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Handshake: the head event is consumed on any cycle where evt_valid && evt_ready;
  // while evt_valid && !evt_ready the head stays stable.
  keypad_evt_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (push_evt_q),
    .pop_i       (evt_ready),
    .head_o      (evt_head),
    .full_o      (fifo_full_unused),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign btn_x     = ~(5'b00001 << row_q);
  assign key_state = key_state_q;
  assign evt_valid = !fifo_empty;
  assign evt_code  = evt_head.code;
  assign overflow  = overflow_q;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign evt_press = evt_head.press;
`else
  logic head_press_unused;
  assign head_press_unused = evt_head.press;
  assign evt_press         = 1'b1;
`endif
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2 (frame = 20 cycles).
module tb_keypad_scanner;
  logic        clk;
  logic        rst;
  logic [4:0]  btn_x;
  logic [3:0]  btn_y;
  logic [19:0] key_state;
  logic        evt_valid;
  logic        evt_ready;
  logic [4:0]  evt_code;
  logic        evt_press;
  logic        overflow;

  logic [19:0] keys;
  int          checks;
  int          failures;
  int          cyc;
  logic [5:0]  exp_q[$];
  logic [5:0]  got_q[$];
  int          got_t[$];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_x     (btn_x),
    .btn_y     (btn_y),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .overflow  (overflow)
  );

  // Clock / reset-relative cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Key matrix model: a closed key pulls its column low while its row is driven.
  always_comb begin
    btn_y = 4'b1111;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 4; c++)
        if (!btn_x[r] && keys[r*4+c]) btn_y[c] = 1'b0;
  end

  // Event monitor
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      got_q.push_back({evt_press, evt_code});
      got_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_events(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    got_t.delete();
    exp_q.delete();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    keys      = '0;
    evt_ready = 1'b1;
    rst       = 1'b1;

    // Reset: 3 cycles, outputs idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_key_state", 32'(key_state), 32'h0);
    check("rst_evt_valid", 32'(evt_valid), 32'h0);
    check("rst_evt_code",  32'(evt_code),  32'h0);
    check("rst_overflow",  32'(overflow),  32'h0);
    check("rst_btn_x",     32'(btn_x),     32'h1e);
    @(negedge clk);
    rst = 1'b0;

    // Row sequence, 4 cycles per row
    tick(1);  check("row_e1",  32'(btn_x), 32'h1e);
    tick(2);  check("row_e3",  32'(btn_x), 32'h1e);
    tick(1);  check("row_e4",  32'(btn_x), 32'h1d);
    tick(4);  check("row_e8",  32'(btn_x), 32'h1b);
    tick(4);  check("row_e12", 32'(btn_x), 32'h17);
    tick(4);  check("row_e16", 32'(btn_x), 32'h0f);
    tick(4);  check("row_e20", 32'(btn_x), 32'h1e);

    // Press key 1: row-0 samples at E24 and E44, event visible after E45
    keys[1] = 1'b1;
    tick(23); check("press_ks_e43", 32'(key_state[1]), 32'h0);
    tick(1);  check("press_ks_e44", 32'(key_state[1]), 32'h1);
              check("press_novalid_e44", 32'(evt_valid), 32'h0);
    tick(1);  check("press_valid_e45", 32'(evt_valid), 32'h1);
              check("press_code_e45",  32'(evt_code),  32'h1);
              check("press_press_e45", 32'(evt_press), 32'h1);
    tick(35);
    exp_q.push_back({1'b1, 5'd1});
    check_events("press_evt");

    // Bounce on key 14: alternating frames never settle
    for (int i = 0; i < 3; i++) begin
      keys[14] = 1'b1;
      tick(20); check("bounce_ks_hi", 32'(key_state[14]), 32'h0);
      keys[14] = 1'b0;
      tick(20); check("bounce_ks_lo", 32'(key_state[14]), 32'h0);
    end
    check_events("bounce_none");
    keys[14] = 1'b1;
    tick(40); check("bounce_ks_held", 32'(key_state[14]), 32'h1);
    exp_q.push_back({1'b1, 5'd14});
    check_events("bounce_evt");

    // Simultaneous press of keys 8 and 11: col 0 first, col 3 one frame later
    keys[8]  = 1'b1;
    keys[11] = 1'b1;
    tick(40); check("simul_ks8_first",  32'(key_state[8]),  32'h1);
              check("simul_ks11_wait",  32'(key_state[11]), 32'h0);
    tick(20); check("simul_ks_all",     32'(key_state),     32'h4902);
    if (got_t.size() == 2) check("simul_spacing", 32'(got_t[1] - got_t[0]), 32'd20);
    else                   check("simul_spacing_n", 32'(got_t.size()), 32'd2);
    exp_q.push_back({1'b1, 5'd8});
    exp_q.push_back({1'b1, 5'd11});
    check_events("simul_evt");

    // Overflow: 5 presses with consumer stalled; 5th (key 19) is dropped
    evt_ready = 1'b0;
    keys[0]  = 1'b1;
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    keys[16] = 1'b1;
    keys[19] = 1'b1;
    tick(40); check("ovf_valid_e340",  32'(evt_valid), 32'h1);
              check("ovf_head_e340",   32'(evt_code),  32'h0);
    tick(20); check("ovf_clear_e360",  32'(overflow),  32'h0);
    tick(20); check("ovf_set_e380",    32'(overflow),  32'h1);
              check("ovf_valid_e380",  32'(evt_valid), 32'h1);
              check("ovf_head_e380",   32'(evt_code),  32'h0);
    evt_ready = 1'b1;
    tick(10); check("ovf_drained",     32'(evt_valid), 32'h0);
              check("ovf_sticky",      32'(overflow),  32'h1);
    exp_q.push_back({1'b1, 5'd0});
    exp_q.push_back({1'b1, 5'd4});
    exp_q.push_back({1'b1, 5'd12});
    exp_q.push_back({1'b1, 5'd16});
    check_events("ovf_evt");
    tick(10);

    // Release key 1
    keys[1] = 1'b0;
    tick(30); check("rel_ks", 32'(key_state[1]), 32'h0);
`ifdef KEYPAD_RELEASE_EVT_EN
    exp_q.push_back({1'b0, 5'd1});
`endif
    check_events("rel_evt");

    // Reset mid-frame with keys held discards all progress
    rst = 1'b1;
    tick(2);  check("mid_rst_ks",       32'(key_state), 32'h0);
              check("mid_rst_valid",    32'(evt_valid), 32'h0);
              check("mid_rst_overflow", 32'(overflow),  32'h0);
              check("mid_rst_btn_x",    32'(btn_x),     32'h1e);
    @(negedge clk);
    rst = 1'b0;
    tick(1);  check("mid_rst_row0", 32'(btn_x), 32'h1e);
    tick(3);  check("mid_rst_row1", 32'(btn_x), 32'h1d);
              check("mid_rst_ks_kept0", 32'(key_state), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000, sets clock cycles each row is driven; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, sets consecutive differing samples needed to change a key state; legal range 2..15.
REQ-003 Port clk  input  1  single system clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port btn_x  output  5  row drive, one-cold; the driven row is 0, others are 1.
REQ-006 Port btn_y  input  4  column sense, active-low; 0 means a key in the driven row is closed.
REQ-007 Port key_state  output  20  debounced level per key; bit index is code = row*4+col; 1 means pressed.
REQ-008 Port evt_valid  output  1  event FIFO is non-empty.
REQ-009 Port evt_ready  input  1  consumer accepts the head event when high with evt_valid.
REQ-010 Port evt_code  output  5  key code of the head event, range 0..19.
REQ-011 Port evt_press  output  1  1 means press event, 0 means release event.
REQ-012 Port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-013 btn_y SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Row index r SHALL cycle 0,1,2,3,4,0 and so on; btn_x SHALL be ~(1<<r); each row is held SCAN_DIV cycles, so one frame is 5*SCAN_DIV cycles.
REQ-015 The synchronized columns SHALL be sampled once per row, in the last dwell cycle (dwell count = SCAN_DIV-1); r advances on the next edge.
REQ-016 Each key SHALL have a debounce counter; a sample equal to key_state clears it; a differing sample increments it.
REQ-017 A key's key_state SHALL toggle on the sample where its counter would reach DEBOUNCE_SCANS; its counter then clears.
REQ-018 Only one toggle SHALL commit per sample, and the lowest column index wins.
REQ-019 Other eligible keys in that row SHALL saturate at DEBOUNCE_SCANS-1 and commit on a later sample of the row if they still differ.
REQ-020 Each toggle SHALL push {press = new key_state bit, code} into a 4-entry FIFO one cycle after the sample; evt_* SHALL show the FIFO head.
REQ-021 A pop SHALL occur when evt_valid && evt_ready; evt_valid, evt_code and evt_press SHALL stay stable while evt_valid && !evt_ready.
REQ-022 Full FIFO, push without pop: the new event SHALL be dropped and overflow set to 1.
REQ-023 Full FIFO, push with simultaneous pop: both SHALL occur, with no drop.
REQ-024 Empty FIFO, push: evt_valid SHALL rise the cycle after the push; there is no bypass.
REQ-025 overflow SHALL clear only on reset.

Reset
REQ-026 On rst: r=0, btn_x=5'b11110, dwell count=0, all debounce counters=0, key_state=0.
REQ-027 On rst: FIFO empty, evt_valid=0, evt_code=0, evt_press=0, overflow=0, synchronizer flops=4'b1111.
REQ-028 Reset asserted mid-frame or mid-debounce SHALL discard all progress; scanning restarts at row 0 on the first edge after release.

Configuration
REQ-029 With KEYPAD_RELEASE_EVT_EN defined, press and release toggles SHALL both generate events.
REQ-030 Without KEYPAD_RELEASE_EVT_EN, only press toggles SHALL push events; release toggles SHALL update key_state only, and evt_press SHALL be constant 1.

Structure
REQ-031 Shared package keypad_pkg SHALL hold KP_ROWS=5, KP_COLS=4, KP_CODE_W=5, KP_FIFO_DEPTH=4 and the event record type {press, code}.
REQ-032 The FIFO SHALL be a sub-module named keypad_evt_fifo with push/pop, full/empty and a drop indication.
REQ-033 The scan counter, row index and debouncers SHALL live in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=2, macro defined unless stated)
REQ-034 Reset test: assert rst for 3 cycles.
- btn_x SHALL be 11110 on the next edge after release.
- btn_x SHALL then follow 11101, 11011, 10111, 01111 at 4-cycle steps.
- All outputs SHALL be 0 during reset.
REQ-035 Press test: hold btn_y=1101 while btn_x=11110, and 1111 otherwise.
- key_state[1]=1 after the 2nd row-0 sample.
- One event code=1, press=1; no further events while held.
REQ-036 Bounce test: toggle the col-2 input of row 3 every other frame.
- key_state[14] SHALL never change and no events SHALL occur.
- Then hold it low for 2 frames: exactly one press event, code=14.
REQ-037 Simultaneous press test: press cols 0 and 3 of row 2 together.
- Event code=8 first, then code=11 exactly one frame later.
- key_state SHALL reach 0x900.
REQ-038 Overflow test: hold evt_ready=0 and generate 5 press events.
- evt_valid SHALL stay 1 and overflow SHALL become 1.
- Popping SHALL return the first 4 codes in order; the 5th is lost.
REQ-039 Release test: release key 1.
- With KEYPAD_RELEASE_EVT_EN: event code=1, press=0.
- Without KEYPAD_RELEASE_EVT_EN: no event, and key_state[1] SHALL fall to 0.
